// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } state_t;

  typedef enum logic {
    REQ_ALU,
    REQ_MEM
  } req_id_t;

  localparam logic [5:0] OP_WRITE = 6'd0;
  localparam logic [5:0] OP_UPPER = 6'd10;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus: ALU and load requesters plus the register-file write port.
// The slave modport is the arbiter's view; master is the surrounding pipeline.
interface rf_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_rz;
  logic [DATA_W-1:0] a_data;
  logic              a_upper;
  logic              m_valid;
  logic              m_ready;
  logic [ADDR_W-1:0] m_rz;
  logic [DATA_W-1:0] m_data;
  logic              m_upper;
  logic              rf_wrt;
  logic [ADDR_W-1:0] rf_rz;
  logic [DATA_W-1:0] rf_data;
  logic [5:0]        rf_opcode;
  logic              rf_done;

  modport master (
    output a_valid, a_rz, a_data, a_upper,
    output m_valid, m_rz, m_data, m_upper,
    output rf_done,
    input  a_ready, m_ready,
    input  rf_wrt, rf_rz, rf_data, rf_opcode
  );

  modport slave (
    input  a_valid, a_rz, a_data, a_upper,
    input  m_valid, m_rz, m_data, m_upper,
    input  rf_done,
    output a_ready, m_ready,
    output rf_wrt, rf_rz, rf_data, rf_opcode
  );
endinterface

// File: rtl/rf_wb_arbiter_rr_arb.sv
// rf_rr_arb: two-requester round-robin arbiter. On contention the requester
// that did not win last time is granted; a lone requester always wins.
module rf_rr_arb
  import rf_wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_m,
  output logic gnt_a,
  output logic gnt_m
);

  req_id_t last;

  // Grant decision, only while enabled
  always_comb begin
    gnt_a = 1'b0;
    gnt_m = 1'b0;
    if (en) begin
      if (req_a && req_m) begin
        if (last == REQ_MEM) gnt_a = 1'b1;
        else                 gnt_m = 1'b1;
      end else if (req_a) begin
        gnt_a = 1'b1;
      end else if (req_m) begin
        gnt_m = 1'b1;
      end
    end
  end

  // Remember the last winner; reset favours the ALU on first contention
  always_ff @(posedge clk) begin
    if (rst)        last <= REQ_MEM;
    else if (gnt_a) last <= REQ_ALU;
    else if (gnt_m) last <= REQ_MEM;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: arbitrates ALU and load writebacks onto one register-file
// write port, flags read-after-write hazards, and times out stuck writes.
// Optional macro RF_WB_BYPASS_EN forwards held non-upper write data to
// matching read ports instead of raising hazard.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  rf_wb_arbiter_if.slave    bus,
  input  logic [ADDR_W-1:0] rd_rx,
  input  logic [ADDR_W-1:0] rd_ry,
  output logic              hazard,
  output logic              fwd_x,
  output logic              fwd_y,
  output logic [DATA_W-1:0] fwd_data,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              timeout;
  logic              gnt_a, gnt_m, take;
  logic [ADDR_W-1:0] cap_rz, hold_rz;
  logic [DATA_W-1:0] hold_data;
  logic              hold_upper;
  logic              match_x, match_y;

  // Reset overrides requests, so no grant is offered while rst is high
  rf_rr_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    ((state == ST_IDLE) && !rst),
    .req_a (bus.a_valid),
    .req_m (bus.m_valid),
    .gnt_a (gnt_a),
    .gnt_m (gnt_m)
  );

  assign take   = gnt_a | gnt_m;
  assign cap_rz = gnt_a ? bus.a_rz : bus.m_rz;

  // Control state: FSM, timeout counter and registered error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= timeout;
      cnt   <= ((state == ST_WRITE) && (state_nxt == ST_WRITE)) ? cnt + CNT_W'(1) : '0;
    end
  end

  // Holding registers for the granted transfer
  always_ff @(posedge clk) begin
    if (take) begin
      hold_rz    <= cap_rz;
      hold_data  <= gnt_a ? bus.a_data  : bus.m_data;
      hold_upper <= gnt_a ? bus.a_upper : bus.m_upper;
    end
  end

  // Next state and write-port outputs; register 0 writes are swallowed in IDLE
  always_comb begin
    state_nxt     = state;
    timeout       = 1'b0;
    bus.a_ready   = gnt_a;
    bus.m_ready   = gnt_m;
    bus.rf_wrt    = 1'b0;
    bus.rf_rz     = '0;
    bus.rf_data   = '0;
    bus.rf_opcode = OP_WRITE;
    busy          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (take && (cap_rz != '0)) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        bus.rf_wrt    = 1'b1;
        bus.rf_rz     = hold_rz;
        bus.rf_data   = hold_data;
        bus.rf_opcode = hold_upper ? OP_UPPER : OP_WRITE;
        busy          = 1'b1;
        if (bus.rf_done) begin
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_nxt = ST_IDLE;
          timeout   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign match_x = (state == ST_WRITE) && (hold_rz != '0) && (hold_rz == rd_rx);
  assign match_y = (state == ST_WRITE) && (hold_rz != '0) && (hold_rz == rd_ry);

  // Hazard and bypass; upper-half writes never forward
  always_comb begin
    fwd_x    = 1'b0;
    fwd_y    = 1'b0;
    fwd_data = '0;
    hazard   = 1'b0;
`ifdef RF_WB_BYPASS_EN
    fwd_x    = match_x && !hold_upper;
    fwd_y    = match_y && !hold_upper;
    fwd_data = (fwd_x || fwd_y) ? hold_data : '0;
    hazard   = (match_x && !fwd_x) || (match_y && !fwd_y);
`else
    hazard   = match_x || match_y;
`endif
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (both bypass builds).
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [4:0]  rd_rx, rd_ry;
  logic        hazard, fwd_x, fwd_y, busy, err;
  logic [31:0] fwd_data;
  int          checks;
  int          errors;

`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  rf_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .TIMEOUT_CYC(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rd_rx    (rd_rx),
    .rd_ry    (rd_ry),
    .hazard   (hazard),
    .fwd_x    (fwd_x),
    .fwd_y    (fwd_y),
    .fwd_data (fwd_data),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rd_rx = 5'd0; rd_ry = 5'd0;
    bus.a_valid = 1'b0; bus.a_rz = '0; bus.a_data = '0; bus.a_upper = 1'b0;
    bus.m_valid = 1'b0; bus.m_rz = '0; bus.m_data = '0; bus.m_upper = 1'b0;
    bus.rf_done = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_wrt", bus.rf_wrt, 0);
    check("rst_rz", bus.rf_rz, 0);
    check("rst_data", bus.rf_data, 0);
    check("rst_op", bus.rf_opcode, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_haz", hazard, 0);
    check("rst_fwd", {fwd_x, fwd_y, fwd_data}, 0);

    // Single ALU write
    rst = 1'b0;
    bus.a_valid = 1'b1; bus.a_rz = 5'd3; bus.a_data = 32'hDEADBEEF; bus.a_upper = 1'b0;
    #1;
    check("alu_ready", {bus.a_ready, bus.m_ready}, 2'b10);
    tick();
    bus.a_valid = 1'b0;
    #1;
    check("alu_ready_drop", bus.a_ready, 0);
    check("alu_wrt", {bus.rf_wrt, busy}, 2'b11);
    check("alu_rz", bus.rf_rz, 3);
    check("alu_data", bus.rf_data, 32'hDEADBEEF);
    check("alu_op", bus.rf_opcode, 0);
    tick();
    check("alu_hold", bus.rf_wrt, 1);
    bus.rf_done = 1'b1;
    #1;
    check("alu_done_cyc", bus.rf_wrt, 1);
    tick();
    bus.rf_done = 1'b0;
    #1;
    check("alu_after_done", {bus.rf_wrt, busy}, 2'b00);

    // Contention twice after reset: ALU then memory
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.a_valid = 1'b1; bus.a_rz = 5'd4; bus.a_data = 32'h44;
    bus.m_valid = 1'b1; bus.m_rz = 5'd5; bus.m_data = 32'h55;
    #1;
    check("rr1_ready", {bus.a_ready, bus.m_ready}, 2'b10);
    tick();
    check("rr1_write_ready", {bus.a_ready, bus.m_ready}, 2'b00);
    check("rr1_rz", bus.rf_rz, 4);
    bus.rf_done = 1'b1;
    tick();
    bus.rf_done = 1'b0;
    #1;
    check("rr2_ready", {bus.a_ready, bus.m_ready}, 2'b01);
    tick();
    bus.a_valid = 1'b0; bus.m_valid = 1'b0;
    #1;
    check("rr2_rz", bus.rf_rz, 5);
    check("rr2_data", bus.rf_data, 32'h55);
    bus.rf_done = 1'b1;
    tick();
    bus.rf_done = 1'b0;

    // Load to r0: accepted, no write, last grant still updated
    bus.m_valid = 1'b1; bus.m_rz = 5'd0;
    #1;
    check("r0_ready", {bus.a_ready, bus.m_ready}, 2'b01);
    tick();
    bus.m_valid = 1'b0;
    #1;
    check("r0_nowrite", {bus.rf_wrt, busy}, 2'b00);
    bus.a_valid = 1'b1; bus.a_rz = 5'd7; bus.a_data = 32'h12345678; bus.a_upper = 1'b0;
    bus.m_valid = 1'b1; bus.m_rz = 5'd9;
    #1;
    check("r0_lastgnt", {bus.a_ready, bus.m_ready}, 2'b10);
    tick();
    bus.a_valid = 1'b0; bus.m_valid = 1'b0;
    rd_rx = 5'd7; rd_ry = 5'd2;
    #1;
    check("haz_x", hazard, !BYP);
    check("fwd_x", {fwd_x, fwd_y}, {BYP, 1'b0});
    check("fwd_data_x", fwd_data, BYP ? 32'h12345678 : 32'h0);
    rd_rx = 5'd2; rd_ry = 5'd7;
    #1;
    check("haz_y", hazard, !BYP);
    check("fwd_y", {fwd_x, fwd_y}, {1'b0, BYP});
    bus.rf_done = 1'b1;
    tick();
    bus.rf_done = 1'b0;
    rd_rx = 5'd7;
    #1;
    check("haz_idle", {hazard, fwd_x, fwd_y}, 3'b000);

    // Upper-half write: always hazards, then left to time out
    bus.a_valid = 1'b1; bus.a_rz = 5'd7; bus.a_data = 32'h0000ABCD; bus.a_upper = 1'b1;
    #1;
    check("up_ready", bus.a_ready, 1);
    tick();
    bus.a_valid = 1'b0; bus.a_upper = 1'b0;
    #1;
    check("up_op", bus.rf_opcode, 10);
    check("up_haz", hazard, 1);
    check("up_fwd", {fwd_x, fwd_y, fwd_data}, 0);
    repeat (14) tick();
    check("to_pending", {bus.rf_wrt, err}, 2'b10);
    tick();
    check("to_err", err, 1);
    check("to_idle", {bus.rf_wrt, busy}, 2'b00);
    bus.m_valid = 1'b1; bus.m_rz = 5'd6; bus.m_data = 32'h66; bus.m_upper = 1'b0;
    #1;
    check("to_regrant", bus.m_ready, 1);
    tick();
    check("to_err_pulse", err, 0);
    check("to_next_rz", {busy, bus.rf_rz}, {1'b1, 5'd6});

    // Reset during WRITE abandons it; reset masks readies
    rst = 1'b1;
    tick();
    check("mid_rst", {bus.rf_wrt, busy, err}, 3'b000);
    check("mid_rst_ready", bus.m_ready, 0);
    rst = 1'b0;
    bus.m_valid = 1'b0;
    #1;
    check("mid_rst_haz", hazard, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DATA_W, 32, register data width.
REQ-002 Parameter ADDR_W, 5, register address width.
REQ-003 Parameter TIMEOUT_CYC, 15, maximum cycles to wait for rf_done.
REQ-004 Single clock; reset synchronous, active-high.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 a_valid/a_ready  in/out  1/1  ALU writeback handshake.
REQ-008 a_rz, a_data, a_upper  in  ADDR_W/DATA_W/1  ALU destination, data, upper-half write flag.
REQ-009 m_valid/m_ready  in/out  1/1  memory-load writeback handshake.
REQ-010 m_rz, m_data, m_upper  in  ADDR_W/DATA_W/1  load destination, data, upper-half flag.
REQ-011 rf_wrt, rf_rz, rf_data, rf_opcode  out  1/ADDR_W/DATA_W/6  register-file write port.
REQ-012 rf_done  in  1  register-file write-complete.
REQ-013 rd_rx, rd_ry  in  ADDR_W  current read addresses.
REQ-014 hazard  out  1  read address matches in-flight write.
REQ-015 fwd_x, fwd_y, fwd_data  out  1/1/DATA_W  bypass selects and data.
REQ-016 busy, err  out  1/1  write in flight; timeout pulse.

Function
REQ-017 FSM states IDLE, WRITE; only IDLE accepts requests.
REQ-018 IDLE with any valid: winner's ready=1 that cycle (combinational), rz/data/upper captured into holding regs, next state WRITE.
REQ-019 Arbitration round-robin: both valid -> requester not granted last wins; one valid -> it wins regardless.
REQ-020 Captured rz==0: transfer accepted, no write issued, stay IDLE, last-grant still updated.
REQ-021 WRITE: rf_wrt=1, rf_rz/rf_data from holding regs, rf_opcode=10 if upper else 0; busy=1.
REQ-022 WRITE with rf_done=1: next state IDLE; rf_wrt deasserts next cycle; no new grant in same cycle as rf_done.
REQ-023 WRITE: cycle counter increments; reaching TIMEOUT_CYC without rf_done -> err=1 one cycle, return IDLE, write dropped.
REQ-024 Both readies never high in same cycle; ready never high outside IDLE.
REQ-025 hazard=1 when state WRITE and held rz equals rd_rx or rd_ry; rz 0 never hazards.
REQ-026 Upper-half writes carry data[15:0] into bits 31:16 semantics; the block passes data unchanged, opcode selects behaviour.

Reset
REQ-027 rst: state IDLE, rf_wrt=0, rf_rz=0, rf_data=0, rf_opcode=0, busy=0, err=0, counter 0, hazard=0, fwd outputs 0.
REQ-028 rst: last-grant = memory, so ALU wins first contention.
REQ-029 rst mid-WRITE abandons the write without err; asserted rst overrides all inputs.

Configuration
REQ-030 Macro RF_WB_BYPASS_EN defined: in WRITE with upper=0, matching read port drives fwd_x/fwd_y=1, fwd_data=held data, hazard suppressed for that match.
REQ-031 RF_WB_BYPASS_EN undefined: fwd_x=fwd_y=0, fwd_data=0 always; hazard per REQ-025.
REQ-032 Upper-half writes never bypass; they raise hazard in both builds.

Structure
REQ-033 Shared package holds state enum, opcode constants OP_WRITE=0, OP_UPPER=10, and requester-ID type.
REQ-034 One sub-module rf_rr_arb: two-request round-robin arbiter, grant and last-grant register.

Verification
REQ-035 Reset then a_valid, a_rz=3, a_data=0xDEADBEEF -> a_ready 1 cycle, rf_wrt=1, rf_rz=3, rf_opcode=0 until rf_done.
REQ-036 a_valid and m_valid together twice -> ALU granted first, memory second, never both ready.
REQ-037 m_valid, m_rz=0 -> m_ready=1, rf_wrt stays 0, FSM stays IDLE.
REQ-038 Write in flight rz=7, rd_rx=7 -> hazard=1 (no bypass); with RF_WB_BYPASS_EN fwd_x=1, fwd_data=held data, hazard=0; upper write rz=7 -> hazard=1 both builds.
REQ-039 rf_done held 0 for 15 cycles -> err pulse, FSM IDLE, next request granted.
REQ-040 rst asserted during WRITE -> next cycle rf_wrt=0, busy=0, err=0.
